// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// word/address geometry used by the loader and its byte assembler.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] ADDR_INC   = 32'd4;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Little-endian 4-lane word assembler: each strobe writes the next byte lane,
// and o_word_full flags the strobe that completes a word.
module byte_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_strobe,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_word;

    // NOTE: the lanes are cleared on reset as well, so an aborted partial word can never leak out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
        end else if (i_strobe) begin
            r_word[{r_idx, 3'b000} +: 8] <= i_byte;
            r_idx                        <= r_idx + IDX_W'(1);
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_strobe && (r_idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: writes little-endian words into CPU memory while
// holding the CPU in reset. Optional trailing XOR checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             Ext_MemWrite,
    output logic [31:0]      Ext_WriteData,
    output logic [31:0]      Ext_DataAdr,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t FINAL_STATE = S_CSUM;
`else
    localparam state_t FINAL_STATE = S_DONE;
`endif

    state_t           r_state, w_next;
    logic [7:0]       r_len_lo;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_words;
    logic [31:0]      r_wdata;
    logic [31:0]      r_adr;
    logic [15:0]      w_hdr;
    logic [31:0]      w_word;
    logic [31:0]      w_adr;
    logic             w_word_full;
    logic             w_clear;
    logic             w_start_ok;
    logic             w_last;
    logic             w_accept;

    assign w_hdr      = {rx_data, r_len_lo};
    assign w_accept   = rx_valid && rx_ready;
    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_last     = (r_words == r_count - CNT_W'(1));
    assign w_adr      = BASE_ADDR + 32'(r_words) * ADDR_INC;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    assign rx_ready = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
`else
    assign rx_ready = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
`endif

    byte_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_strobe    (rx_valid && (r_state == S_DATA)),
        .i_byte      (rx_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_next       = r_state;
        w_clear      = 1'b0;
        Ext_MemWrite = 1'b0;
        cpu_reset    = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_LEN0;
            S_LEN0: begin
                busy = 1'b1;
                if (rx_valid) w_next = S_LEN1;
            end
            S_LEN1: begin
                busy = 1'b1;
                if (rx_valid) begin
                    if (w_hdr == 16'd0)                    w_next = FINAL_STATE;
                    else if ({16'd0, w_hdr} > MAX_WORDS)   w_next = S_ERR;
                    else begin
                        w_clear = 1'b1;
                        w_next  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                busy = 1'b1;
                if (w_word_full) w_next = S_WRITE;
            end
            S_WRITE: begin
                busy         = 1'b1;
                Ext_MemWrite = 1'b1;
                w_next       = w_last ? FINAL_STATE : S_DATA;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                busy = 1'b1;
                if (rx_valid) w_next = (rx_data == r_csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) w_next = S_LEN0;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) w_next = S_LEN0;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The write word index is words_loaded itself: it restarts at zero with every session.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len_lo <= '0;
            r_count  <= '0;
            r_words  <= '0;
            r_wdata  <= '0;
            r_adr    <= BASE_ADDR;
        end else begin
            if (r_state == S_LEN0 && w_accept) r_len_lo <= rx_data;
            if (r_state == S_LEN1 && w_accept) r_count  <= CNT_W'(w_hdr);
            if (w_start_ok) begin
                r_words <= '0;
            end else if (r_state == S_WRITE) begin
                r_words <= r_words + CNT_W'(1);
                r_wdata <= w_word;
                r_adr   <= w_adr;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset)                             r_csum <= '0;
        else if (w_start_ok)                    r_csum <= '0;
        else if (r_state == S_DATA && w_accept) r_csum <= r_csum ^ rx_data;
    end
`endif

    // The word and address are live during WRITE and held afterwards.
    assign Ext_WriteData = (r_state == S_WRITE) ? w_word : r_wdata;
    assign Ext_DataAdr   = (r_state == S_WRITE) ? w_adr  : r_adr;
    assign words_loaded  = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader: load sessions, stalls, header
// corner cases, mid-session abort and (when enabled) checksum accept/reject.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        Ext_MemWrite;
    logic [31:0] Ext_WriteData;
    logic [31:0] Ext_DataAdr;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    prog_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .Ext_MemWrite  (Ext_MemWrite),
        .Ext_WriteData (Ext_WriteData),
        .Ext_DataAdr   (Ext_DataAdr),
        .cpu_reset     (cpu_reset),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_bad    = 0;
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];

    // Write capture; a write must never coincide with rx_ready or a released CPU.
    always @(negedge clk) begin
        if (Ext_MemWrite === 1'b1) begin
            wr_adr_q.push_back(Ext_DataAdr);
            wr_dat_q.push_back(Ext_WriteData);
            if (rx_ready !== 1'b0 || cpu_reset !== 1'b1) n_bad++;
        end
    end

    typedef struct {
        string       name;
        logic [15:0] count;
        int          nbytes;
        logic [63:0] data;
        bit          stall;
        int          nwr;
        logic [63:0] exp_adr;
        logic [63:0] exp_dat;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_words;
        logic        exp_cpu_reset;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input string n, input logic [15:0] cnt, input int nb,
                                input logic [63:0] d, input bit st, input int nw,
                                input logic [63:0] ea, input logic [63:0] ed,
                                input logic dn, input logic er, input logic [15:0] wl,
                                input logic cr);
        vec_t v;
        v.name = n; v.count = cnt; v.nbytes = nb; v.data = d; v.stall = st;
        v.nwr = nw; v.exp_adr = ea; v.exp_dat = ed; v.exp_done = dn; v.exp_err = er;
        v.exp_words = wl; v.exp_cpu_reset = cr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit sent;
        sent = 1'b0;
        if (stall) begin
            rx_valid = 1'b0;
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int c = 0; c < 20 && !sent; c++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) sent = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!sent) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: byte %h not accepted, expected acceptance within 20 cycles", b);
        end
    endtask

    task automatic check_writes(input string tag, input int base, input int nwr,
                                input logic [63:0] ea, input logic [63:0] ed);
        check({tag, "_nwrites"}, 32'(wr_adr_q.size() - base), 32'(nwr));
        for (int k = 0; k < nwr; k++) begin
            if (base + k < wr_adr_q.size()) begin
                check($sformatf("%s_adr%0d", tag, k), wr_adr_q[base+k], ea[32*k +: 32]);
                check($sformatf("%s_dat%0d", tag, k), wr_dat_q[base+k], ed[32*k +: 32]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   base;
        int   bad0;
        logic [7:0] cs;

        vecs[0] = mk("basic",    16'd2,      8, 64'hDEADBEEF_12345678, 1'b0, 2,
                     64'h00000004_00000000, 64'hDEADBEEF_12345678, 1'b1, 1'b0, 16'd2, 1'b0);
        vecs[1] = mk("stalled",  16'd2,      8, 64'hDEADBEEF_12345678, 1'b1, 2,
                     64'h00000004_00000000, 64'hDEADBEEF_12345678, 1'b1, 1'b0, 16'd2, 1'b0);
        vecs[2] = mk("zero",     16'd0,      0, 64'h0,                 1'b0, 0,
                     64'h0,                 64'h0,                 1'b1, 1'b0, 16'd0, 1'b0);
        vecs[3] = mk("overflow", 16'h0101,   0, 64'h0,                 1'b0, 0,
                     64'h0,                 64'h0,                 1'b0, 1'b1, 16'd0, 1'b1);
        vecs[4] = mk("recover",  16'd1,      4, 64'h00000000_CAFEF00D, 1'b1, 1,
                     64'h0,                 64'h00000000_CAFEF00D, 1'b1, 1'b0, 16'd1, 1'b0);

        // Reset values
        tick();
        tick();
        check("rst_cpu_reset", 32'(cpu_reset),    32'd1);
        check("rst_rx_ready",  32'(rx_ready),     32'd0);
        check("rst_memwrite",  32'(Ext_MemWrite), 32'd0);
        check("rst_wdata",     Ext_WriteData,     32'h0);
        check("rst_adr",       Ext_DataAdr,       32'h0);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_done",      32'(done),         32'd0);
        check("rst_error",     32'(error),        32'd0);
        check("rst_words",     32'(words_loaded), 32'd0);
        reset = 1'b1;
        tick();

`ifndef PROG_LOADER_CHECKSUM_EN
        // Zero count: DONE on the edge that accepts the second header byte
        base = wr_adr_q.size();
        pulse_start();
        send_byte(8'h00, 1'b0);
        check("zero_busy_mid", 32'(busy), 32'd1);
        send_byte(8'h00, 1'b0);
        check("zero_done_now",  32'(done),      32'd1);
        check("zero_cpu_now",   32'(cpu_reset), 32'd0);
        check("zero_nwr_now",   32'(wr_adr_q.size() - base), 32'd0);
`endif

        foreach (vecs[v]) begin
            base = wr_adr_q.size();
            bad0 = n_bad;
            cs   = 8'h00;
            pulse_start();
            check({vecs[v].name, "_busy_start"},  32'(busy),         32'd1);
            check({vecs[v].name, "_words_clear"}, 32'(words_loaded), 32'd0);
            check({vecs[v].name, "_flags_clear"}, 32'({done, error}), 32'd0);
            send_byte(vecs[v].count[7:0],  vecs[v].stall);
            send_byte(vecs[v].count[15:8], vecs[v].stall);
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                send_byte(vecs[v].data[8*i +: 8], vecs[v].stall);
                cs = cs ^ vecs[v].data[8*i +: 8];
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (vecs[v].count <= 16'd256) send_byte(cs, vecs[v].stall);
`endif
            tick();
            tick();
            check_writes(vecs[v].name, base, vecs[v].nwr, vecs[v].exp_adr, vecs[v].exp_dat);
            check({vecs[v].name, "_done"},      32'(done),         32'(vecs[v].exp_done));
            check({vecs[v].name, "_error"},     32'(error),        32'(vecs[v].exp_err));
            check({vecs[v].name, "_words"},     32'(words_loaded), 32'(vecs[v].exp_words));
            check({vecs[v].name, "_cpu_reset"}, 32'(cpu_reset),    32'(vecs[v].exp_cpu_reset));
            check({vecs[v].name, "_busy_end"},  32'(busy),         32'd0);
            check({vecs[v].name, "_rx_ready"},  32'(rx_ready),     32'd0);
            check({vecs[v].name, "_write_ctx"}, 32'(n_bad - bad0), 32'd0);
        end

        // Abort after two bytes of word 0
        base = wr_adr_q.size();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        reset = 1'b0;
        tick();
        check("abort_cpu_reset", 32'(cpu_reset),    32'd1);
        check("abort_rx_ready",  32'(rx_ready),     32'd0);
        check("abort_memwrite",  32'(Ext_MemWrite), 32'd0);
        check("abort_wdata",     Ext_WriteData,     32'h0);
        check("abort_adr",       Ext_DataAdr,       32'h0);
        check("abort_flags",     32'({busy, done, error}), 32'd0);
        check("abort_words",     32'(words_loaded), 32'd0);
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        tick();
        tick();
        rx_valid = 1'b0;
        check("abort_idle_ready", 32'(rx_ready), 32'd0);
        check("abort_nwr", 32'(wr_adr_q.size() - base), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum accept then reject
        base = wr_adr_q.size();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h0F, 1'b0);
        tick();
        tick();
        check_writes("csum_ok", base, 1, 64'h0, 64'h00000000_08040201);
        check("csum_ok_done",  32'(done),      32'd1);
        check("csum_ok_error", 32'(error),     32'd0);
        check("csum_ok_cpu",   32'(cpu_reset), 32'd0);

        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h0E, 1'b0);
        tick();
        tick();
        check("csum_bad_done",  32'(done),      32'd0);
        check("csum_bad_error", 32'(error),     32'd1);
        check("csum_bad_cpu",   32'(cpu_reset), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
